bram_dp_param: RTL and testbench

Parametrised true dual-port block RAM with a shared clock. Generalises the fixed 8192x2 dual-port BRAM wrapper to any width and depth, and adds four behaviours:
- per-bit write masks that are actually honoured;
- an optional output pipeline register;
- deterministic cross-port collision resolution with a collision flag;
- a post-reset clear sequencer.

It sits between the memory-generator output and the accelerator datapath, and is the default storage leaf for all generated memories.

---
 rtl/bram_dp_param_if.sv | 31 +++
 rtl/bram_dp_param.sv | 113 +++++++++++
 tb/tb_bram_dp_param.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bram_dp_param_if.sv
// Port bundle for the dual-port BRAM: two address/data/enable/mask groups
// plus the read data, clear-busy and collision status returned by the memory.
interface bram_dp_param_if #(
    parameter int WIDTH  = 2,
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;
    logic [WIDTH-1:0]  d0;
    logic [WIDTH-1:0]  d1;
    logic [WIDTH-1:0]  wem0;
    logic [WIDTH-1:0]  wem1;
    logic              we0;
    logic              we1;
    logic              ce0;
    logic              ce1;
    logic [WIDTH-1:0]  q0;
    logic [WIDTH-1:0]  q1;
    logic              busy;
    logic              coll;

    modport master (
        output a0, a1, d0, d1, wem0, wem1, we0, we1, ce0, ce1,
        input  q0, q1, busy, coll
    );

    modport slave (
        input  a0, a1, d0, d1, wem0, wem1, we0, we1, ce0, ce1,
        output q0, q1, busy, coll
    );
endinterface

// File: rtl/bram_dp_param.sv
// True dual-port RAM on one clock: bit-masked writes, read-first reads, port-0-wins
// collision merge with a COLL pulse, optional output register, post-reset clear.
//
//   state   | meaning
//   S_CLEAR | writing CLEAR_VALUE to mem[r_cnt] each edge; ports ignored, busy=1
//   S_READY | normal dual-port operation, held until reset
module bram_dp_param #(
    parameter int              WIDTH          = 2,
    parameter int              DEPTH          = 8192,
    parameter int              ADDR_W         = 13,
    parameter int              OUT_REG        = 0,
    parameter int              CLEAR_ON_RESET = 1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    bram_dp_param_if.slave   io_mem
);
    typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]  r_s1_q0, r_s1_q1, r_s2_q0, r_s2_q1;
    logic              r_coll;

    logic              w_busy, w_act0, w_act1, w_ok0, w_ok1;
    logic              w_wr0, w_wr1, w_wr_both, w_same;
    logic [WIDTH-1:0]  w_rd0, w_rd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == S_CLEAR) begin
            if (r_cnt == LAST_ADDR) begin
                w_state_nxt = S_READY;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    assign w_busy    = (r_state == S_CLEAR);
    assign w_act0    = io_mem.ce0 & ~w_busy;
    assign w_act1    = io_mem.ce1 & ~w_busy;
    // Only matters for non-power-of-two depths; otherwise always true.
    assign w_ok0     = ({1'b0, io_mem.a0} < DEPTH_W);
    assign w_ok1     = ({1'b0, io_mem.a1} < DEPTH_W);
    assign w_same    = (io_mem.a0 == io_mem.a1);
    assign w_wr0     = w_act0 & io_mem.we0 & w_ok0;
    assign w_wr1     = w_act1 & io_mem.we1 & w_ok1;
    assign w_wr_both = w_wr0 & w_wr1 & w_same;
    assign w_rd0     = w_ok0 ? r_mem[io_mem.a0] : '0;
    assign w_rd1     = w_ok1 ? r_mem[io_mem.a1] : '0;

    // Same-address dual write is merged into one update so port 0 bits win.
    always_ff @(posedge i_clk) begin
        if (w_busy) begin
            r_mem[r_cnt] <= CLEAR_VALUE;
        end else if (w_wr_both) begin
            r_mem[io_mem.a0] <= (r_mem[io_mem.a0] & ~(io_mem.wem0 | io_mem.wem1))
                              | (io_mem.d0 & io_mem.wem0)
                              | (io_mem.d1 & io_mem.wem1 & ~io_mem.wem0);
        end else begin
            if (w_wr0) begin
                r_mem[io_mem.a0] <= (r_mem[io_mem.a0] & ~io_mem.wem0) | (io_mem.d0 & io_mem.wem0);
            end
            if (w_wr1) begin
                r_mem[io_mem.a1] <= (r_mem[io_mem.a1] & ~io_mem.wem1) | (io_mem.d1 & io_mem.wem1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_q0 <= '0;
            r_s1_q1 <= '0;
            r_s2_q0 <= '0;
            r_s2_q1 <= '0;
            r_coll  <= 1'b0;
        end else begin
            if (w_act0) begin
                r_s1_q0 <= w_rd0;
            end
            if (w_act1) begin
                r_s1_q1 <= w_rd1;
            end
            r_s2_q0 <= r_s1_q0;
            r_s2_q1 <= r_s1_q1;
            r_coll  <= w_act0 & w_act1 & w_same & (io_mem.we0 | io_mem.we1);
        end
    end

    assign io_mem.q0   = (OUT_REG != 0) ? r_s2_q0 : r_s1_q0;
    assign io_mem.q1   = (OUT_REG != 0) ? r_s2_q1 : r_s1_q1;
    assign io_mem.busy = w_busy;
    assign io_mem.coll = r_coll;
endmodule

// File: tb/tb_bram_dp_param.sv
// Directed bench: two instances (OUT_REG=0 and OUT_REG=1) share every input;
// a vector table covers access rules, plus reset/clear and CE-hold sequences.
module tb_bram_dp_param;
    localparam int         W  = 8;
    localparam int         D  = 12;
    localparam int         AW = 4;
    localparam logic [7:0] CV = 8'hA5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_dp_param_if #(.WIDTH(W), .ADDR_W(AW)) bus0 ();
    bram_dp_param_if #(.WIDTH(W), .ADDR_W(AW)) bus1 ();

    assign bus1.a0   = bus0.a0;
    assign bus1.a1   = bus0.a1;
    assign bus1.d0   = bus0.d0;
    assign bus1.d1   = bus0.d1;
    assign bus1.wem0 = bus0.wem0;
    assign bus1.wem1 = bus0.wem1;
    assign bus1.we0  = bus0.we0;
    assign bus1.we1  = bus0.we1;
    assign bus1.ce0  = bus0.ce0;
    assign bus1.ce1  = bus0.ce1;

    bram_dp_param #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .OUT_REG(0),
                    .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV))
        dut0 (.i_clk(clk), .i_rst_n(rst_n), .io_mem(bus0));

    bram_dp_param #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .OUT_REG(1),
                    .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV))
        dut1 (.i_clk(clk), .i_rst_n(rst_n), .io_mem(bus1));

    typedef struct {
        logic       ce0, we0;
        logic [3:0] a0;
        logic [7:0] d0, m0;
        logic       ce1, we1;
        logic [3:0] a1;
        logic [7:0] d1, m1;
        logic [7:0] eq0, eq1;
        logic       ecoll;
    } vec_t;

    vec_t vt[$];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(input logic ce0, we0, input logic [3:0] a0,
                                input logic [7:0] d0, m0,
                                input logic ce1, we1, input logic [3:0] a1,
                                input logic [7:0] d1, m1,
                                input logic [7:0] eq0, eq1, input logic ecoll);
        vec_t v;
        v.ce0 = ce0; v.we0 = we0; v.a0 = a0; v.d0 = d0; v.m0 = m0;
        v.ce1 = ce1; v.we1 = we1; v.a1 = a1; v.d1 = d1; v.m1 = m1;
        v.eq0 = eq0; v.eq1 = eq1; v.ecoll = ecoll;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus0.ce0 = v.ce0; bus0.we0 = v.we0; bus0.a0 = v.a0; bus0.d0 = v.d0; bus0.wem0 = v.m0;
        bus0.ce1 = v.ce1; bus0.we1 = v.we1; bus0.a1 = v.a1; bus0.d1 = v.d1; bus0.wem1 = v.m1;
    endtask

    task automatic idle();
        drive(mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0));
    endtask

    task automatic read1(input string name, input logic [3:0] a, input logic [7:0] exp);
        drive(mk(0,0,0,0,0, 1,0,a,0,0, 0,0,0));
        @(posedge clk); #1;
        chk(name, bus0.q1, exp);
    endtask

    // Counts edges from reset release until busy drops; ports may be driven meanwhile.
    task automatic wait_clear(input string name);
        int   n = 0;
        logic coll_seen = 1'b0;
        logic q_moved   = 1'b0;
        chk({name, " busy at release"}, {7'b0, bus0.busy}, 8'h01);
        while (bus0.busy && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bus0.coll || bus1.coll) coll_seen = 1'b1;
            if (bus0.q0 !== 8'h00 || bus0.q1 !== 8'h00 || bus1.q0 !== 8'h00 || bus1.q1 !== 8'h00)
                q_moved = 1'b1;
        end
        chk({name, " busy edges"}, 8'(n), 8'(D));
        chk({name, " coll during clear"}, {7'b0, coll_seen}, 8'h00);
        chk({name, " q moved during clear"}, {7'b0, q_moved}, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pq0, pq1;

        for (int i = 0; i < D; i++)
            vt.push_back(mk(0,0,0,0,0, 1,0,4'(i),0,0, 8'h00,CV,0));
        vt.push_back(mk(0,0,0,0,0,            1,0,12,0,0,          8'h00,8'h00,0));
        vt.push_back(mk(0,0,0,0,0,            1,0,13,0,0,          8'h00,8'h00,0));
        vt.push_back(mk(1,1,3,8'hFF,8'h0F,    0,0,0,0,0,           8'hA5,8'h00,0));
        vt.push_back(mk(0,0,0,0,0,            1,0,3,0,0,           8'hA5,8'hAF,0));
        vt.push_back(mk(1,0,3,0,0,            0,0,0,0,0,           8'hAF,8'hAF,0));
        vt.push_back(mk(1,1,5,8'h11,8'hF0,    1,1,5,8'h22,8'hFF,   8'hA5,8'hA5,1));
        vt.push_back(mk(0,0,0,0,0,            1,0,5,0,0,           8'hA5,8'h12,0));
        vt.push_back(mk(1,1,7,8'h3C,8'hFF,    1,0,7,0,0,           8'hA5,8'hA5,1));
        vt.push_back(mk(0,0,0,0,0,            1,0,7,0,0,           8'hA5,8'h3C,0));
        vt.push_back(mk(1,0,7,0,0,            1,0,7,0,0,           8'h3C,8'h3C,0));
        vt.push_back(mk(0,1,0,8'h00,8'hFF,    0,0,0,0,0,           8'h3C,8'h3C,0));
        vt.push_back(mk(0,0,0,0,0,            1,0,0,0,0,           8'h3C,8'hA5,0));
        vt.push_back(mk(1,0,9,0,0,            1,1,9,8'h5A,8'hFF,   8'hA5,8'hA5,1));
        vt.push_back(mk(1,0,9,0,0,            0,0,0,0,0,           8'h5A,8'hA5,0));
        vt.push_back(mk(1,1,12,8'h00,8'hFF,   0,0,0,0,0,           8'h00,8'hA5,0));
        vt.push_back(mk(1,0,11,0,0,           0,0,0,0,0,           8'hA5,8'hA5,0));
        vt.push_back(mk(1,1,11,8'hC3,8'hFF,   1,0,10,0,0,          8'hA5,8'hA5,0));
        vt.push_back(mk(0,0,0,0,0,            1,0,11,0,0,          8'hA5,8'hC3,0));

        idle();
        #12;
        chk("reset q0", bus0.q0, 8'h00);
        chk("reset q1", bus0.q1, 8'h00);
        chk("reset coll", {7'b0, bus0.coll}, 8'h00);
        chk("reset busy", {7'b0, bus0.busy}, 8'h01);
        @(posedge clk); #2;
        rst_n = 1'b1;
        wait_clear("clear1");

        pq0 = 8'h00;
        pq1 = 8'h00;
        foreach (vt[i]) begin
            drive(vt[i]);
            @(posedge clk); #1;
            chk($sformatf("row%0d q0", i),      bus0.q0, vt[i].eq0);
            chk($sformatf("row%0d q1", i),      bus0.q1, vt[i].eq1);
            chk($sformatf("row%0d coll", i),    {7'b0, bus0.coll}, {7'b0, vt[i].ecoll});
            chk($sformatf("row%0d oreg q0", i), bus1.q0, pq0);
            chk($sformatf("row%0d oreg q1", i), bus1.q1, pq1);
            chk($sformatf("row%0d oreg coll", i), {7'b0, bus1.coll}, {7'b0, vt[i].ecoll});
            pq0 = vt[i].eq0;
            pq1 = vt[i].eq1;
        end

        // Latency-2 read then CE hold on the registered-output instance.
        drive(mk(1,0,9,0,0, 0,0,0,0,0, 0,0,0));
        @(posedge clk); #1;
        chk("oreg pre q0", bus0.q0, 8'h5A);
        drive(mk(1,0,2,0,0, 0,0,0,0,0, 0,0,0));
        @(posedge clk); #1;
        chk("oreg lat1 q0", bus1.q0, 8'h5A);
        drive(mk(0,0,9,0,0, 0,0,0,0,0, 0,0,0));
        @(posedge clk); #1;
        chk("oreg lat2 q0", bus1.q0, CV);
        for (int k = 0; k < 3; k++) begin
            drive(mk(0,0,4'(9 - k),0,0, 0,0,0,0,0, 0,0,0));
            @(posedge clk); #1;
            chk($sformatf("oreg hold%0d q0", k), bus1.q0, CV);
            chk($sformatf("ce hold%0d q0", k), bus0.q0, CV);
        end

        // Async reset while coll is high, then reset in the middle of the clear.
        drive(mk(1,1,4,8'h77,8'hFF, 1,0,4,0,0, 0,0,0));
        @(posedge clk); #1;
        chk("pre-reset coll", {7'b0, bus0.coll}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst q0", bus0.q0, 8'h00);
        chk("async rst q1", bus0.q1, 8'h00);
        chk("async rst oreg q0", bus1.q0, 8'h00);
        chk("async rst coll", {7'b0, bus0.coll}, 8'h00);
        chk("async rst busy", {7'b0, bus0.busy}, 8'h01);
        @(posedge clk); #2;
        rst_n = 1'b1;
        drive(mk(1,1,0,8'h00,8'hFF, 1,1,0,8'h00,8'hFF, 0,0,0));
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
        end
        chk("mid-clear busy", {7'b0, bus0.busy}, 8'h01);
        chk("mid-clear coll", {7'b0, bus0.coll}, 8'h00);
        #1 rst_n = 1'b0;
        #1;
        chk("mid rst q1", bus0.q1, 8'h00);
        chk("mid rst coll", {7'b0, bus0.coll}, 8'h00);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_clear("clear2");
        idle();
        read1("post-clear addr0", 0, CV);
        read1("post-clear addr4", 4, CV);
        read1("post-clear addr9", 9, CV);
        read1("post-clear addr11", 11, CV);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
